// File: rtl/output_serializer_pkg.sv
// Shared constants, pair type and width helpers for the output serializer.
package output_serializer_pkg;

  localparam int DEFAULT_WIDTH = 24;
  localparam int DEFAULT_DEPTH = 4;

  // Instantiating scopes redeclare this with their own Width; older sample sits in the low half.
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] newer;
    logic [DEFAULT_WIDTH-1:0] older;
  } pair_default_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/output_serializer_pair_fifo.sv
// Generic pair FIFO: storage, wrap-bit pointers, full/empty and synchronous flush.
module pair_fifo
  import output_serializer_pkg::*;
#(
  parameter int DW    = 2 * DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int PW   = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [PW-1:0] used
);

  localparam int AW = PW - 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign used    = wr_ptr - rd_ptr;
  assign push    = wr_en && !full;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is zeroed only by reset so the idle read path is deterministic; flush leaves it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (!clear && push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/output_serializer.sv
// Accepts result pairs and drains them one sample per cycle, older sample first.
// Optional activation clamp on the read path: OUTPUT_SERIALIZER_RELU_EN.
module output_serializer
  import output_serializer_pkg::*;
#(
  parameter int Width = DEFAULT_WIDTH,
  parameter int Depth = DEFAULT_DEPTH,
  localparam int CW   = cnt_w(Depth)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic [Width-1:0] din0,
  input  logic [Width-1:0] din1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [Width-1:0] dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  localparam int PW = ptr_w(Depth);

  typedef struct packed {
    logic [Width-1:0] newer;
    logic [Width-1:0] older;
  } pair_t;

  pair_t         wr_pair, head;
  logic          full, empty, phase, pop;
  logic [PW-1:0] used;
  logic [Width-1:0] sel;

  assign wr_pair = '{newer: din1, older: din0};

  pair_fifo #(.DW(2 * Width), .DEPTH(Depth)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (clear),
    .wr_en   (in_valid),
    .wr_data (wr_pair),
    .rd_en   (pop && phase),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .used    (used)
  );

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign count     = CW'({used, 1'b0}) - CW'(phase);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      phase <= 1'b0;
    else if (clear)
      phase <= 1'b0;
    else if (pop)
      phase <= ~phase;
  end

  assign sel = phase ? head.newer : head.older;

`ifdef OUTPUT_SERIALIZER_RELU_EN
  assign dout = sel[Width-1] ? '0 : sel;
`else
  assign dout = sel;
`endif

endmodule

// File: tb/tb_output_serializer.sv
// Scoreboard bench for output_serializer: directed pushes, monitor compares the drained stream.
module tb_output_serializer;

  localparam int W = 24;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          clear = 1'b0;
  logic [W-1:0]  din0 = '0;
  logic [W-1:0]  din1 = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  dout;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [3:0]    count;

  int n_cmp = 0;
  int n_err = 0;
  int acc_cnt = 0;
  logic [W-1:0] sb [$];

  output_serializer #(.Width(W), .Depth(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (clear),
    .din0      (din0),
    .din1      (din1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dout      (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] expect_sample(input logic [W-1:0] d);
`ifdef OUTPUT_SERIALIZER_RELU_EN
    return d[W-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 60) begin
      step();
      n++;
    end
    chk("drain_done", {31'd0, out_valid}, 32'd0);
    chk("sb_empty", sb.size(), 0);
    out_ready = 1'b0;
  endtask

  // Handshakes are judged mid-cycle, when inputs and registered outputs are stable.
  always @(negedge clk) begin
    if (!rstn || clear) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL stream_underflow: got 0x%0h, expected no output", dout);
        end else begin
          chk("stream", dout, sb.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(expect_sample(din0));
        sb.push_back(expect_sample(din1));
        acc_cnt++;
      end
    end
  end

  initial begin
    repeat (3) step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", count, 0);
    chk("rst_dout", dout, 0);
    rstn = 1'b1;
    step();

    // Single pair drains in order
    out_ready = 1'b1;
    din0 = 24'h000011; din1 = 24'h000022; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1_count2", count, 2);
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_dout0", dout, 24'h000011);
    step();
    chk("t1_count1", count, 1);
    chk("t1_dout1", dout, 24'h000022);
    step();
    chk("t1_count0", count, 0);
    chk("t1_valid_drop", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Fill to capacity with the consumer stalled
    for (int i = 0; i < 4; i++) begin
      din0 = 24'h000100 + 24'(i); din1 = 24'h000200 + 24'(i); in_valid = 1'b1;
      step();
    end
    din0 = 24'h000555; din1 = 24'h000666;
    chk("t2_full", {31'd0, in_ready}, 32'd0);
    chk("t2_count8", count, 8);
    step();
    step();
    chk("t2_count_hold", count, 8);
    chk("t2_dout_hold", dout, 24'h000100);
    chk("t2_accepts", acc_cnt, 5);

    // Full FIFO, both sides streaming
    acc_cnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din0 = 24'h000300 + 24'(i); din1 = 24'h000400 + 24'(i); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("t3_accepts", acc_cnt, 7);
    drain();

    // Clear with a concurrent push while phase is 1
    din0 = 24'h000a01; din1 = 24'h000a02; in_valid = 1'b1;
    step();
    din0 = 24'h000b01; din1 = 24'h000b02;
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t4_count3", count, 3);
    clear = 1'b1; in_valid = 1'b1; din0 = 24'h000777; din1 = 24'h000888;
    step();
    clear = 1'b0; in_valid = 1'b0;
    chk("t4_count0", count, 0);
    chk("t4_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("t4_absent", {31'd0, out_valid}, 32'd0);

    // Negative sample through the optional clamp
    din0 = 24'hFFFFF0; din1 = 24'h000005; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
`ifdef OUTPUT_SERIALIZER_RELU_EN
    chk("t5_dout_neg", dout, 24'h000000);
`else
    chk("t5_dout_neg", dout, 24'hFFFFF0);
`endif
    out_ready = 1'b1;
    step();
    chk("t5_dout_pos", dout, 24'h000005);
    step();
    chk("t5_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Asynchronous reset mid-drain
    din0 = 24'h000c01; din1 = 24'h000c02; in_valid = 1'b1;
    step();
    din0 = 24'h000d01; din1 = 24'h000d02;
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    #2 rstn = 1'b0;
    #1;
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_count", count, 0);
    chk("t6_dout", dout, 0);
    chk("t6_ready", {31'd0, in_ready}, 32'd1);
    step();
    step();
    rstn = 1'b1;
    step();
    out_ready = 1'b0;
    din0 = 24'h000abc; din1 = 24'h000def; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t6_restart_count", count, 2);
    chk("t6_restart_dout", dout, 24'h000abc);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
